// File: rtl/ones_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// ones_pkg
// Shared types and constants for the thermometer pattern generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ones_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Requests above WIDTH saturate to a full pattern.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// ones_pattern_gen_if
// Count-in / pattern-out bundle of the thermometer pattern generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ones_pattern_gen_if;
  import ones_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] count;
  logic             ser_out;
  logic             ser_valid;
  logic [WIDTH-1:0] pattern;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  // Producer of counts / consumer of patterns.
  modport master (
    output in_valid, count, out_ready,
    input  in_ready, ser_out, ser_valid, pattern, out_valid, overflow
  );

  // The generator itself.
  modport slave (
    input  in_valid, count, out_ready,
    output in_ready, ser_out, ser_valid, pattern, out_valid, overflow
  );

endinterface

`default_nettype wire

// File: rtl/ones_pattern_gen.sv
// ---------------------------------------------------------------------------
// ones_pattern_gen
// Turns a binary ones-count into a WIDTH-bit thermometer pattern, emitted
// serially LSB first and assembled in parallel.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ones_pattern_gen
  import ones_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ones_pattern_gen_if.slave  bus
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_clamped;
  logic [CNT_W-1:0] idx_next;

  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic [WIDTH-1:0] pattern;
  logic             out_valid;
  logic             overflow;

  assign cnt_clamped = clamp_count(bus.count);
  assign idx_next    = CNT_W'(idx) + CNT_W'(1);

  // Single FSM: every output is a register, so the serial bit for index k is
  // computed one edge ahead and lands in cycle accept+1+k.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      pattern   <= '0;
      overflow  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt       <= cnt_clamped;
            overflow  <= (bus.count > CNT_W'(WIDTH));
            pattern   <= '0;
            idx       <= '0;
            ser_out   <= (cnt_clamped != '0);
            ser_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          pattern[idx] <= ser_out;
          if (idx == IDX_W'(WIDTH - 1)) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx     <= idx + IDX_W'(1);
            ser_out <= (idx_next < cnt);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          ser_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out;
  assign bus.ser_valid = ser_valid;
  assign bus.pattern   = pattern;
  assign bus.out_valid = out_valid;
  assign bus.overflow  = overflow;

endmodule

`default_nettype wire

// File: tb/tb_ones_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_ones_pattern_gen
// Self-checking bench for ones_pattern_gen.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ones_pattern_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   acc_cyc;
  int   prev_acc;

  ones_pattern_gen_if bus ();

  ones_pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a count n produces n ones packed at the bottom.
  function automatic int ref_ones(input int c);
    return (c > 8) ? 8 : c;
  endfunction

  function automatic logic [7:0] ref_pattern(input int c);
    logic [8:0] full;
    full = (9'd1 << ref_ones(c)) - 9'd1;
    return full[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a count and wait for it to be taken; afterwards we are in cycle E0+1.
  task automatic accept(input int c);
    int waited;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    chk("accept_timeout", 32'(waited < 50), 32'd1);
    bus.in_valid = 1'b1;
    bus.count    = 4'(c);
    step();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.count    = 4'($urandom_range(0, 15));
  endtask

  task automatic check_shift(input int c);
    logic [7:0] exp;
    exp = ref_pattern(c);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ser_valid[%0d]", k), 32'(bus.ser_valid), 32'd1);
      chk($sformatf("ser_out[%0d] c=%0d", k, c), 32'(bus.ser_out), 32'(exp[k]));
      chk($sformatf("out_valid_early[%0d]", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("in_ready_shift[%0d]", k), 32'(bus.in_ready), 32'd0);
      step();
    end
  endtask

  task automatic check_done(input int c);
    chk($sformatf("out_valid c=%0d", c), 32'(bus.out_valid), 32'd1);
    chk($sformatf("pattern c=%0d", c), 32'(bus.pattern), 32'(ref_pattern(c)));
    chk($sformatf("popcount c=%0d", c), 32'($countones(bus.pattern)), 32'(ref_ones(c)));
    chk($sformatf("overflow c=%0d", c), 32'(bus.overflow), 32'(c > 8));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("ser_valid_done", 32'(bus.ser_valid), 32'd0);
  endtask

  // Hold DONE for stalls cycles, then let the consumer take the pattern.
  task automatic release_done(input int c, input int stalls);
    bus.out_ready = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      step();
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_pattern", 32'(bus.pattern), 32'(ref_pattern(c)));
    end
    bus.out_ready = 1'b1;
    step();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_txn(input int c, input int stalls);
    accept(c);
    check_shift(c);
    check_done(c);
    release_done(c, stalls);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    acc_cyc       = 0;
    prev_acc      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.count     = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("rst_ser_out", 32'(bus.ser_out), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pattern", 32'(bus.pattern), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // count=3 basic
    run_txn(3, 2);

    // count=0 then count=8 back-to-back, out_ready tied high
    bus.out_ready = 1'b1;
    accept(0);
    prev_acc = acc_cyc;
    check_shift(0);
    check_done(0);
    step();
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    accept(8);
    chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'd10);
    check_shift(8);
    check_done(8);
    release_done(8, 0);

    // Clamp + overflow, then a normal count clears overflow
    run_txn(12, 1);
    run_txn(5, 0);

    // DONE held with in_valid pulses that must be ignored
    accept(3);
    check_shift(3);
    check_done(3);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 20; s++) begin
      bus.in_valid = (s % 3 == 0);
      bus.count    = 4'd2;
      step();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_pattern", 32'(bus.pattern), 32'h07);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("hold_no_accept", 32'(bus.ser_valid), 32'd0);

    // Reset in the middle of a shift
    accept(6);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_pattern", 32'(bus.pattern), 32'd0);
    chk("midrst_ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("midrst_no_out_valid", 32'(bus.out_valid), 32'd0);
    end
    run_txn(6, 0);

    // Sweep all counts with random stalls, then random counts
    for (int c = 0; c < 16; c++) run_txn(c, $urandom_range(0, 3));
    for (int n = 0; n < 10; n++) run_txn($urandom_range(0, 15), $urandom_range(0, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
